// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// A downstream stall never drops an upstream beat. Flush inserts a bubble with zero control.
// A saturating stall counter is exported for hazard-unit debug.
module pipe_stage_skid #(
  parameter int unsigned CTRL_W          = 9,
  parameter int unsigned DATA_W          = 111,
  parameter bit          FLUSH_ZERO_DATA = 1'b1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding is {main_v, skid_v}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b10,
    StTwo   = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic skid_v;
  logic acc_in;
  logic acc_out;

  assign skid_v    = state_q[0];
  assign out_valid = state_q[1];
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

  // Held low during reset so no beat ever looks accepted by a stage that is being cleared.
  assign in_ready = rst_n && !skid_v && !flush;
  assign acc_in   = in_valid && in_ready;
  assign acc_out  = out_valid && out_ready;

  // Next-state for occupancy and the main/skid entries.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = StEmpty;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (FLUSH_ZERO_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (acc_in) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = StOne;
          end
        end
        StOne: begin
          if (acc_in && acc_out) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (acc_in) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = StTwo;
          end else if (acc_out) begin
            // Data is left as-is; only control must read zero while empty.
            main_ctrl_d = '0;
            state_d     = StEmpty;
          end
        end
        StTwo: begin
          if (acc_out) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
            state_d     = StOne;
          end
        end
        default: begin
          state_d     = StEmpty;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  // Saturating count of stalled cycles; flush cycles are not counted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && !flush && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
